// File: rtl/fc_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fc_feeder
// Purpose  : Collects one 12ch x 4x4 int8 pooled map from a byte stream and
//            replays it to the fc neurons as 6-lane beats in two 16-beat
//            bursts, with idle gaps so the neuron pipeline can drain.
// Revision : 1.0 - initial release
// ============================================================================
module fc_feeder #(
    parameter int GAP_CYCLES = 8,
    parameter int CH_NUM     = 12,
    parameter int POS_NUM    = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       ivalid,
    output logic [7:0] din_0,
    output logic [7:0] din_1,
    output logic [7:0] din_2,
    output logic [7:0] din_3,
    output logic [7:0] din_4,
    output logic [7:0] din_5,
    output logic       last,
    output logic       busy
);

    localparam int         c_LANES     = 6;
    localparam int         c_MAP_SIZE  = CH_NUM * POS_NUM;
    localparam logic [7:0] c_MAP_LAST  = 8'(c_MAP_SIZE - 1);
    localparam logic [7:0] c_GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [3:0] c_BEAT_LAST = 4'(POS_NUM - 1);
    localparam logic [3:0] c_HALF_CH   = 4'(CH_NUM / 2);

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_SEND0 = 3'd1,
        S_GAP0  = 3'd2,
        S_SEND1 = 3'd3,
        S_GAP1  = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_wr_addr;
    logic [3:0] r_beat;
    logic [7:0] r_gap;
    logic       r_ivalid;
    logic       r_last;
    logic [7:0] r_din [c_LANES];
    logic [7:0] r_buf [c_MAP_SIZE];

    logic       w_accept;
    logic [3:0] w_nxt_beat;
    logic       w_rd_half;
    logic [3:0] w_rd_beat;
    logic [7:0] w_rd_data [c_LANES];

    assign w_accept   = (r_state == S_FILL) && in_valid;
    assign w_nxt_beat = r_beat + 4'd1;

    // Select which beat the lane registers load next: the upcoming beat of
    // the current burst, or beat 0 of the burst about to start.
    always_comb begin
        w_rd_half = 1'b0;
        w_rd_beat = 4'd0;
        case (r_state)
            S_SEND0: w_rd_beat = w_nxt_beat;
            S_GAP0:  w_rd_half = 1'b1;
            S_SEND1: begin
                w_rd_half = 1'b1;
                w_rd_beat = w_nxt_beat;
            end
            default: begin
                w_rd_half = 1'b0;
                w_rd_beat = 4'd0;
            end
        endcase
    end

    // Lane k reads channel k (first burst) or k+6 (second burst); the buffer
    // address is simply {channel, position}.
    generate
        for (genvar k = 0; k < c_LANES; k++) begin : g_lane
            logic [3:0] w_chan;
            assign w_chan       = 4'(k) + (w_rd_half ? c_HALF_CH : 4'd0);
            assign w_rd_data[k] = r_buf[{w_chan, w_rd_beat}];
        end
    endgenerate

    // Map buffer write port; contents need no reset since a fresh map is
    // always fully written before it is read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_addr] <= in_data;
        end
    end

    // Fill / burst / gap sequencer with registered lane outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_FILL;
            r_wr_addr <= 8'd0;
            r_beat    <= 4'd0;
            r_gap     <= 8'd0;
            r_ivalid  <= 1'b0;
            r_last    <= 1'b0;
            for (int k = 0; k < c_LANES; k++) begin
                r_din[k] <= 8'd0;
            end
        end else begin
            case (r_state)
                S_FILL: begin
                    if (in_valid) begin
                        if (r_wr_addr == c_MAP_LAST) begin
                            // Beat 0 never touches byte 191, so it can be
                            // presented on the very next cycle.
                            r_wr_addr <= 8'd0;
                            r_state   <= S_SEND0;
                            r_beat    <= 4'd0;
                            r_ivalid  <= 1'b1;
                            r_last    <= 1'b0;
                            for (int k = 0; k < c_LANES; k++) begin
                                r_din[k] <= w_rd_data[k];
                            end
                        end else begin
                            r_wr_addr <= r_wr_addr + 8'd1;
                        end
                    end
                end
                S_SEND0: begin
                    if (r_beat == c_BEAT_LAST) begin
                        r_state  <= S_GAP0;
                        r_beat   <= 4'd0;
                        r_gap    <= 8'd0;
                        r_ivalid <= 1'b0;
                    end else begin
                        r_beat <= w_nxt_beat;
                        for (int k = 0; k < c_LANES; k++) begin
                            r_din[k] <= w_rd_data[k];
                        end
                    end
                end
                S_GAP0: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state  <= S_SEND1;
                        r_gap    <= 8'd0;
                        r_ivalid <= 1'b1;
                        r_last   <= 1'b0;
                        for (int k = 0; k < c_LANES; k++) begin
                            r_din[k] <= w_rd_data[k];
                        end
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                S_SEND1: begin
                    if (r_beat == c_BEAT_LAST) begin
                        r_state  <= S_GAP1;
                        r_beat   <= 4'd0;
                        r_gap    <= 8'd0;
                        r_ivalid <= 1'b0;
                        r_last   <= 1'b0;
                    end else begin
                        r_beat <= w_nxt_beat;
                        r_last <= (w_nxt_beat == c_BEAT_LAST);
                        for (int k = 0; k < c_LANES; k++) begin
                            r_din[k] <= w_rd_data[k];
                        end
                    end
                end
                S_GAP1: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= S_FILL;
                        r_gap   <= 8'd0;
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_FILL);
    assign busy     = (r_state != S_FILL);
    assign ivalid   = r_ivalid;
    assign last     = r_last;
    assign din_0    = r_din[0];
    assign din_1    = r_din[1];
    assign din_2    = r_din[2];
    assign din_3    = r_din[3];
    assign din_4    = r_din[4];
    assign din_5    = r_din[5];

endmodule
`default_nettype wire
